// File: rtl/regfile_sequencer.sv
// Register-transfer sequencer: accepts one op per handshake, reads two registers,
// runs a small ALU op and writes the result back over the RegisterFile port set.
module regfile_sequencer #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [ADDR_W-1:0] op_rs1,
    input  logic [ADDR_W-1:0] op_rs2,
    input  logic [ADDR_W-1:0] op_rd,
    input  logic [WIDTH-1:0]  op_imm,
    output logic [ADDR_W-1:0] rf_ra1,
    output logic [ADDR_W-1:0] rf_ra2,
    input  logic [WIDTH-1:0]  rf_rd1,
    input  logic [WIDTH-1:0]  rf_rd2,
    output logic [ADDR_W-1:0] rf_wa3,
    output logic [WIDTH-1:0]  rf_wd3,
    output logic              rf_we3,
    output logic              busy,
    output logic              done,
    output logic              flag_z,
    output logic              flag_c
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;
    typedef enum logic [1:0] {OP_LOADI, OP_ADD, OP_SUB, OP_AND} op_t;

    state_t              state_q, state_d;
    op_t                 code_q, code_d;
    logic [ADDR_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [WIDTH-1:0]    imm_q, imm_d, a_q, a_d, b_q, b_d, result_q, result_d;
    logic                carry_q, carry_d, flag_z_q, flag_z_d, flag_c_q, flag_c_d;
    logic [WIDTH:0]      alu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            code_q   <= OP_LOADI;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    // ALU is one bit wider so bit WIDTH carries ADD carry-out / SUB borrow.
    always_comb begin
        alu = '0;
        case (code_q)
            OP_LOADI: alu = {1'b0, imm_q};
            OP_ADD:   alu = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:   alu = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:   alu = {1'b0, a_q & b_q};
            default:  alu = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        op_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        rf_ra1   = '0;
        rf_ra2   = '0;
        rf_wa3   = '0;
        rf_wd3   = '0;
        rf_we3   = 1'b0;
        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    code_d  = op_t'(op_code);
                    rs1_d   = op_rs1;
                    rs2_d   = op_rs2;
                    rd_d    = op_rd;
                    imm_d   = op_imm;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                busy    = 1'b1;
                rf_ra1  = rs1_q;
                rf_ra2  = rs2_q;
                a_d     = rf_rd1;
                b_d     = rf_rd2;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                busy     = 1'b1;
                result_d = alu[WIDTH-1:0];
                carry_d  = alu[WIDTH];
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                busy     = 1'b1;
                done     = 1'b1;
                rf_we3   = 1'b1;
                rf_wa3   = rd_q;
                rf_wd3   = result_q;
                flag_z_d = (result_q == '0);
                flag_c_d = carry_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer with a behavioural 8x8 register file on the rf_* ports.
module tb_regfile_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [1:0] op_code;
    logic [2:0] op_rs1, op_rs2, op_rd;
    logic [7:0] op_imm;
    logic [2:0] rf_ra1, rf_ra2, rf_wa3;
    logic [7:0] rf_rd1, rf_rd2, rf_wd3;
    logic       rf_we3, busy, done, flag_z, flag_c;

    typedef struct packed {
        logic [2:0] rd;
        logic [7:0] wd;
        logic       z;
        logic       c;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend;
    logic flag_pend = 1'b0;
    int   checks = 0;
    int   passed = 0;

    logic [7:0] rf_mem [8] = '{default: 8'h00};

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_we3) rf_mem[rf_wa3] <= rf_wd3;
    assign rf_rd1 = rf_mem[rf_ra1];
    assign rf_rd2 = rf_mem[rf_ra2];

    regfile_sequencer #(.WIDTH(8), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_rs1(op_rs1), .op_rs2(op_rs2), .op_rd(op_rd), .op_imm(op_imm),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_wa3(rf_wa3), .rf_wd3(rf_wd3), .rf_we3(rf_we3),
        .busy(busy), .done(done), .flag_z(flag_z), .flag_c(flag_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every done pulse, checks flags one cycle later.
    always @(negedge clk) begin
        if (!rst_n) begin
            flag_pend = 1'b0;
        end else begin
            chk("we3_only_in_write", 32'(rf_we3), 32'(done));
            if (flag_pend) begin
                chk("flag_z", 32'(flag_z), 32'(pend.z));
                chk("flag_c", 32'(flag_c), 32'(pend.c));
                flag_pend = 1'b0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    pend = exp_q.pop_front();
                    chk("wa3", 32'(rf_wa3), 32'(pend.rd));
                    chk("wd3", 32'(rf_wd3), 32'(pend.wd));
                    flag_pend = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!op_ready && n < 20);
        if (!op_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive(input logic [1:0] code, input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [2:0] rd, input logic [7:0] imm);
        op_code = code; op_rs1 = rs1; op_rs2 = rs2; op_rd = rd; op_imm = imm;
        op_valid = 1'b1;
    endtask

    task automatic issue(input logic [1:0] code, input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [2:0] rd, input logic [7:0] imm,
                         input logic [7:0] ewd, input logic ez, input logic ec);
        int n = 0;
        wait_ready();
        exp_q.push_back('{rd: rd, wd: ewd, z: ez, c: ec});
        drive(code, rs1, rs2, rd, imm);
        @(posedge clk);
        #1 op_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 10);
        chk("done_latency", 32'(n), 32'd3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ready_cnt, busy_cnt, k;
        logic [11:0] ready_mask;
        logic [7:0]  r5_before;
        logic        seen;

        rst_n = 1'b0; op_valid = 1'b0; op_code = '0;
        op_rs1 = '0; op_rs2 = '0; op_rd = '0; op_imm = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we3", 32'(rf_we3), 32'd0);
        chk("rst_wd3", 32'(rf_wd3), 32'd0);
        chk("rst_ra1", 32'(rf_ra1), 32'd0);
        chk("rst_flags", 32'({flag_z, flag_c}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(op_ready), 32'd1);

        issue(2'b00, 3'd0, 3'd0, 3'd1, 8'h8A, 8'h8A, 1'b0, 1'b0);
        chk("r1_loadi", 32'(rf_mem[1]), 32'h8A);
        issue(2'b01, 3'd1, 3'd1, 3'd2, 8'h00, 8'h14, 1'b0, 1'b1);
        chk("r2_add", 32'(rf_mem[2]), 32'h14);
        issue(2'b00, 3'd0, 3'd0, 3'd3, 8'h0A, 8'h0A, 1'b0, 1'b0);
        issue(2'b10, 3'd3, 3'd1, 3'd4, 8'h00, 8'h80, 1'b0, 1'b1);
        chk("r4_sub", 32'(rf_mem[4]), 32'h80);
        issue(2'b11, 3'd1, 3'd3, 3'd1, 8'h00, 8'h0A, 1'b0, 1'b0);
        chk("r1_and", 32'(rf_mem[1]), 32'h0A);
        issue(2'b01, 3'd1, 3'd1, 3'd7, 8'h00, 8'h14, 1'b0, 1'b0);
        chk("r7_raw_add", 32'(rf_mem[7]), 32'h14);

        // op_valid held across three ops: ready every 4th cycle, busy the other 3
        wait_ready();
        exp_q.push_back('{rd: 3'd2, wd: 8'h01, z: 1'b0, c: 1'b0});
        exp_q.push_back('{rd: 3'd3, wd: 8'h02, z: 1'b0, c: 1'b0});
        exp_q.push_back('{rd: 3'd4, wd: 8'h03, z: 1'b0, c: 1'b0});
        ready_cnt = 0; busy_cnt = 0; k = 0; ready_mask = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (busy) busy_cnt++;
            if (op_ready) begin
                ready_cnt++;
                ready_mask[cyc] = 1'b1;
                case (k)
                    0: drive(2'b00, 3'd0, 3'd0, 3'd2, 8'h01);
                    1: drive(2'b00, 3'd0, 3'd0, 3'd3, 8'h02);
                    default: drive(2'b01, 3'd2, 3'd3, 3'd4, 8'h00);
                endcase
                k++;
            end
        end
        @(negedge clk);
        op_valid = 1'b0;
        chk("held_ready_cnt", 32'(ready_cnt), 32'd3);
        chk("held_busy_cnt", 32'(busy_cnt), 32'd9);
        chk("held_ready_mask", 32'(ready_mask), 32'h111);
        @(posedge clk);
        #1 chk("r4_held_add", 32'(rf_mem[4]), 32'h03);

        issue(2'b10, 3'd1, 3'd1, 3'd6, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("r6_zero", 32'(rf_mem[6]), 32'h00);

        // reset asserted during EXEC of LOADI r5=0xFF
        wait_ready();
        r5_before = rf_mem[5];
        drive(2'b00, 3'd0, 3'd0, 3'd5, 8'hFF);
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy_read", 32'(busy), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we3", 32'(rf_we3), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_wd3", 32'(rf_wd3), 32'd0);
        chk("abort_flags", 32'({flag_z, flag_c}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(op_ready), 32'd1);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rf_we3 || done) seen = 1'b1;
        end
        chk("abort_no_write", 32'(seen), 32'd0);
        chk("abort_r5", 32'(rf_mem[5]), 32'(r5_before));

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
